// File: rtl/countdown_ctrl.sv
// countdown_ctrl: prescaled down-counter with pause, abort and optional auto-reload.
// Priority each edge is abort > start > pause > tick.
module countdown_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
    logic [7:0]       pre_q, pre_d;
    logic             done_q, done_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pre_d    = pre_q;
        done_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
        end else if (start && (state_q == IDLE || state_q == DONE)) begin
            reload_d = load_val;
            count_d  = load_val;
            pre_d    = '0;
            state_d  = (load_val == '0) ? DONE : RUN;
            done_d   = (load_val == '0);
        end else if (state_q == RUN) begin
            if (pause) begin
                state_d = PAUSE;
            end else if (pre_q == PRE_MAX) begin
                pre_d = '0;
                // Terminal tick reloads or parks at zero; a zero count never wraps.
                if (count_q == WIDTH'(1)) begin
                    done_d  = 1'b1;
                    count_d = auto_reload ? reload_q : '0;
                    state_d = auto_reload ? RUN : DONE;
                end else if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end else if (state_q == PAUSE && !pause) begin
            state_d = RUN;
        end
    end
    assign count = count_q;
    assign state = state_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSE);
    assign done  = done_q;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: two instances (PRESCALE 1 and 3) sharing stimulus, checked every
// cycle against an elapsed-cycle reference model, plus directed literal expectations.
module tb_countdown_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, pause = 1'b0, abort = 1'b0, auto_reload = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] cnt_o [2];
    logic [1:0] st_o [2];
    logic       busy_o [2];
    logic       dn_o [2];
    int checks = 0, errors = 0;
    int m_st [2], m_cnt [2], m_rl [2], m_ph [2], m_dn [2];
    int t_st [2], t_cnt [2], t_rl [2], t_ph [2], t_dn [2];

    always #5 clk = ~clk;

    countdown_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .auto_reload(auto_reload), .load_val(load_val),
        .count(cnt_o[0]), .busy(busy_o[0]), .done(dn_o[0]), .state(st_o[0]));
    countdown_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .auto_reload(auto_reload), .load_val(load_val),
        .count(cnt_o[1]), .busy(busy_o[1]), .done(dn_o[1]), .state(st_o[1]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: ph counts RUN cycles since the last tick; a tick fires when it reaches p.
    function automatic void step(input int p, input int st, input int cnt, input int rl, input int ph,
                                 output int nst, output int ncnt, output int nrl, output int nph,
                                 output int ndn);
        nst = st; ncnt = cnt; nrl = rl; nph = ph; ndn = 0;
        if (abort) begin
            nst = 0; ncnt = 0; nph = 0;
        end else if (start && (st == 0 || st == 3)) begin
            nrl = int'(load_val); ncnt = int'(load_val); nph = 0;
            nst = (load_val == 0) ? 3 : 1;
            ndn = (load_val == 0) ? 1 : 0;
        end else if (st == 1 && pause) begin
            nst = 2;
        end else if (st == 1) begin
            if (ph + 1 == p) begin
                nph = 0;
                if (cnt == 1) begin
                    ndn = 1;
                    ncnt = auto_reload ? rl : 0;
                    nst = auto_reload ? 1 : 3;
                end else if (cnt > 0) ncnt = cnt - 1;
            end else nph = ph + 1;
        end else if (st == 2 && !pause) begin
            nst = 1;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k] <= 0; m_cnt[k] <= 0; m_rl[k] <= 0; m_ph[k] <= 0; m_dn[k] <= 0;
            end else begin
                step(k == 0 ? 1 : 3, m_st[k], m_cnt[k], m_rl[k], m_ph[k],
                     t_st[k], t_cnt[k], t_rl[k], t_ph[k], t_dn[k]);
                m_st[k] <= t_st[k]; m_cnt[k] <= t_cnt[k]; m_rl[k] <= t_rl[k];
                m_ph[k] <= t_ph[k]; m_dn[k] <= t_dn[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model count[%0d]", k), int'(cnt_o[k]), m_cnt[k]);
            chk($sformatf("model state[%0d]", k), int'(st_o[k]), m_st[k]);
            chk($sformatf("model busy[%0d]", k), int'(busy_o[k]), (m_st[k] == 1 || m_st[k] == 2) ? 1 : 0);
            chk($sformatf("model done[%0d]", k), int'(dn_o[k]), m_dn[k]);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset count", int'(cnt_o[0]), 0);
        chk("reset state", int'(st_o[0]), 0);
        chk("reset busy", int'(busy_o[0]), 0);
        cyc();
        chk("idle without start", int'(st_o[1]), 0);
        // 3,2,1,0 with a single done pulse
        load_val = 4'd3; start = 1'b1; cyc(); start = 1'b0;
        chk("seq3 c3", int'(cnt_o[0]), 3);
        cyc(); chk("seq3 c2", int'(cnt_o[0]), 2);
        cyc(); chk("seq3 c1", int'(cnt_o[0]), 1); chk("seq3 done early", int'(dn_o[0]), 0);
        cyc(); chk("seq3 c0", int'(cnt_o[0]), 0); chk("seq3 done", int'(dn_o[0]), 1);
        chk("seq3 state", int'(st_o[0]), 3); chk("seq3 busy", int'(busy_o[0]), 0);
        cyc(); chk("seq3 done clear", int'(dn_o[0]), 0); chk("seq3 hold", int'(cnt_o[0]), 0);
        // auto-reload 2,1,2,1,2
        load_val = 4'd2; auto_reload = 1'b1; start = 1'b1; cyc(); start = 1'b0;
        chk("ar c2", int'(cnt_o[0]), 2);
        cyc(); chk("ar c1", int'(cnt_o[0]), 1);
        cyc(); chk("ar reload", int'(cnt_o[0]), 2); chk("ar done", int'(dn_o[0]), 1);
        chk("ar state", int'(st_o[0]), 1);
        cyc(); chk("ar c1b", int'(cnt_o[0]), 1); chk("ar done clear", int'(dn_o[0]), 0);
        cyc(); chk("ar reload2", int'(cnt_o[0]), 2); chk("ar done2", int'(dn_o[0]), 1);
        auto_reload = 1'b0; abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort state", int'(st_o[0]), 0); chk("abort count", int'(cnt_o[0]), 0);
        // PRESCALE=3 with a 5-cycle pause at count 3
        load_val = 4'd4; start = 1'b1; cyc(); start = 1'b0;
        chk("ps c4", int'(cnt_o[1]), 4);
        cyc(2); chk("ps still 4", int'(cnt_o[1]), 4);
        cyc(); chk("ps c3", int'(cnt_o[1]), 3);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("pause count", int'(cnt_o[1]), 3);
            chk("pause state", int'(st_o[1]), 2);
            chk("pause busy", int'(busy_o[1]), 1);
        end
        pause = 1'b0; cyc(); chk("resume state", int'(st_o[1]), 1);
        cyc(2); chk("resume still 3", int'(cnt_o[1]), 3);
        cyc(); chk("resume c2", int'(cnt_o[1]), 2);
        abort = 1'b1; cyc(); abort = 1'b0;
        // zero load and ignored restart
        load_val = 4'd0; start = 1'b1; cyc(); start = 1'b0;
        chk("zero state", int'(st_o[0]), 3); chk("zero done", int'(dn_o[0]), 1);
        chk("zero count", int'(cnt_o[0]), 0);
        cyc(); chk("zero done clear", int'(dn_o[0]), 0);
        load_val = 4'd5; start = 1'b1; cyc();
        load_val = 4'd9; cyc(); start = 1'b0;
        chk("restart ignored p3", int'(cnt_o[1]), 5);
        chk("restart ignored p1", int'(cnt_o[0]), 4);
        abort = 1'b1; cyc(); abort = 1'b0;
        // asynchronous reset mid-RUN, then abort beats start
        load_val = 4'd9; start = 1'b1; cyc(); start = 1'b0; cyc();
        chk("pre-rst count", int'(cnt_o[1]), 9);
        #2 rst = 1'b1;
        #1 chk("async rst count", int'(cnt_o[1]), 0);
        chk("async rst state", int'(st_o[1]), 0);
        chk("async rst busy", int'(busy_o[1]), 0);
        @(negedge clk); rst = 1'b0;
        load_val = 4'd5; start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk("abort wins", int'(st_o[0]), 0); chk("abort wins count", int'(cnt_o[1]), 0);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            abort = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 5) == 0);
            auto_reload = ($urandom_range(0, 2) == 0);
            load_val = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, counter and load-value width in bits.
REQ-002 Parameter PRESCALE, default 1, clk cycles per decrement tick (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level-sampled each edge; launches countdown from load_val.
REQ-006 pause  input  1  level; holds countdown while high.
REQ-007 abort  input  1  level-sampled; returns block to IDLE.
REQ-008 auto_reload  input  1  sampled at each terminal tick; 1 = reload and continue.
REQ-009 load_val  input  WIDTH  start value, captured into reload register on accepted start.
REQ-010 count  output  WIDTH  current registered count value.
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 done  output  1  registered one-cycle pulse at terminal count.
REQ-013 state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-014 The block SHALL contain a WIDTH-bit reload register, a WIDTH-bit down count, an 8-bit prescaler and a 4-state FSM; no other state.
REQ-015 Input priority per edge SHALL be abort > start > pause > tick.
REQ-016 abort=1 in any state SHALL set state IDLE, count 0, prescaler 0 and done 0 at that edge.
REQ-017 In IDLE or DONE, start=1 SHALL capture load_val into the reload register, set count=load_val, clear the prescaler and enter RUN; if load_val==0 it SHALL enter DONE instead, with done=1 for that cycle.
REQ-018 start in RUN or PAUSE SHALL be ignored (no restart).
REQ-019 In RUN the prescaler SHALL increment every cycle; a tick occurs on the edge where prescaler==PRESCALE-1, at which the prescaler returns to 0 and count decrements by 1.
REQ-020 A tick with count==1 is terminal: done=1 for exactly one cycle; if auto_reload=1, count is set to the reload register and state stays RUN; otherwise count is set to 0 and state goes to DONE.
REQ-021 count SHALL never wrap below 0 or change except per REQ-016, REQ-017, REQ-019 and REQ-020.
REQ-022 pause=1 in RUN SHALL enter PAUSE at that edge with count and prescaler frozen, overriding any tick due on that edge.
REQ-023 In PAUSE, pause=0 SHALL return to RUN; the prescaler resumes from its frozen value.
REQ-024 DONE SHALL hold count=0 and busy=0 until start or abort.
REQ-025 busy and state SHALL be registered; busy SHALL equal (state==RUN or state==PAUSE) in every cycle.
REQ-026 done SHALL be 0 in every cycle not covered by REQ-017 or REQ-020.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force state IDLE, count 0, reload register 0, prescaler 0, busy 0 and done 0, including mid-RUN or mid-PAUSE.
REQ-028 After rst deasserts, the first state change SHALL occur on the first posedge clk with start=1.

Verification
REQ-029 PRESCALE=1, load_val=3, auto_reload=0, 1-cycle start -> count 3,2,1,0 on consecutive edges; done=1 only in the cycle count becomes 0; state DONE, busy 0.
REQ-030 PRESCALE=1, load_val=2, auto_reload=1 -> count 2,1,2,1,2,...; done pulses on each 1->2 edge; state stays RUN.
REQ-031 PRESCALE=3, load_val=4 -> count decrements every 3rd edge; pause for 5 cycles at count 3 -> count holds 3, state PAUSE, busy 1; resumes with the remaining prescaler phase.
REQ-032 load_val=0 with start -> state DONE next edge, done=1 for one cycle, count 0; start during RUN -> no change in count.
REQ-033 rst pulse asserted asynchronously mid-cycle with count=9 in RUN -> count 0, state IDLE immediately; abort with start in the same cycle -> IDLE, abort wins.
